serial_deserializer: RTL and testbench

- Receive-side counterpart of the universal shift register used as a parallel-to-serial transmitter.
- Accepts an idle-high serial frame: one start bit (0), BIT_WIDTH data bits, one stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks; the block samples it mid-bit and assembles a parallel word.
- Presents the word through a one-entry valid/ready output buffer, with frame-error and overrun reporting.

---
 rtl/serial_deserializer.sv | 145 ++++++++++++++
 tb/tb_serial_deserializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// Serial frame receiver: start, data, stop sampled mid-bit.
// One-entry valid/ready output buffer with frame-error and overrun flags.
module serial_deserializer #(
  parameter int bit_width    = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 sin,
  input  logic                 dir,
  output logic [bit_width-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = (CLKS_PER_BIT > 2) ?
                        $clog2(CLKS_PER_BIT) : 1;
  localparam int IW   = $clog2(bit_width + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(bit_width - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [bit_width-1:0] sr;
  logic                 dir_q;

  logic cnt_clr;
  logic confirm;
  logic shift;
  logic stop_smp;
  logic good;

  assign busy = (state != IDLE);
  assign good = stop_smp & sin;

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and per-edge control strobes
  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    confirm  = 1'b0;
    shift    = 1'b0;
    stop_smp = 1'b0;
    unique case (state)
      IDLE: begin
        if (!sin) begin
          state_n = START;
          cnt_clr = 1'b1;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_clr = 1'b1;
          if (sin) begin
            state_n = IDLE;
          end else begin
            confirm = 1'b1;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_clr = 1'b1;
          shift   = 1'b1;
          if (idx == IDX_LAST) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_clr  = 1'b1;
          stop_smp = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit timer: counts clocks within the current bit
  always_ff @(posedge clk) begin
    if (clr)                cnt <= '0;
    else if (cnt_clr)       cnt <= '0;
    else if (state != IDLE) cnt <= cnt + CW'(1);
  end

  // Bit index, latched direction and shift register
  always_ff @(posedge clk) begin
    if (clr) begin
      idx   <= '0;
      dir_q <= 1'b0;
      sr    <= '0;
    end else begin
      if (confirm) begin
        idx   <= '0;
        dir_q <= dir;
      end else if (shift) begin
        idx <= idx + IW'(1);
        if (dir_q) sr <= {sr[bit_width-2:0], sin};
        else       sr <= {sin, sr[bit_width-1:1]};
      end
    end
  end

  // Output buffer, handshake and error flags
  always_ff @(posedge clk) begin
    if (clr) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_smp & ~sin;
      if (good && (!dout_valid || dout_ready)) begin
        dout       <= sr;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (good && dout_valid && !dout_ready)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer.
// Frame-level reference model with randomized frames.
module tb_serial_deserializer;

  localparam int BW   = 8;
  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;

  logic          clk;
  logic          clr;
  logic          sin;
  logic          dir;
  logic [BW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          frame_err;
  logic          overrun;

  serial_deserializer #(
    .bit_width   (BW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .sin       (sin),
    .dir       (dir),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  logic [BW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovr;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h",
                  tag, obs, exp);
  endtask

  task automatic check_buf(input string tag);
    check({tag, ".valid"}, 32'(dout_valid), 32'(m_valid));
    check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    if (m_valid)
      check({tag, ".dout"}, 32'(dout), 32'(m_dout));
  endtask

  task automatic model_reset();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Sends one frame; returns just after the stop-sample edge.
  task automatic frame(input logic [BW-1:0] data,
                       input logic d,
                       input logic stopb,
                       input logic rdy,
                       input string tag);
    dout_ready = rdy;
    dir = d;
    sin = 1'b0;
    repeat (CPB) @(negedge clk);
    dir = 1'($urandom);
    for (int k = 0; k < BW; k++) begin
      sin = d ? data[BW-1-k] : data[k];
      repeat (CPB) @(negedge clk);
    end
    sin = stopb;
    repeat (HALF + 1) @(negedge clk);
    if (rdy) m_valid = 1'b0;
    if (stopb) begin
      if (!m_valid) begin
        m_dout  = data;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
    check_buf(tag);
    check({tag, ".ferr"}, 32'(frame_err), 32'(!stopb));
    check({tag, ".busy"}, 32'(busy), 32'd0);
    dout_ready = 1'b0;
  endtask

  task automatic gap(input int n, input string tag);
    sin = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0)
        check({tag, ".ferr_clr"}, 32'(frame_err), 32'd0);
    end
  endtask

  task automatic consume(input string tag);
    dout_ready = 1'b1;
    sin = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    m_valid = 1'b0;
    check_buf(tag);
  endtask

  task automatic false_start(input string tag);
    sin = 1'b0;
    @(negedge clk);
    sin = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".ferr"}, 32'(frame_err), 32'd0);
    check_buf(tag);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    clr        = 1'b1;
    sin        = 1'b1;
    dir        = 1'b0;
    dout_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.dout", 32'(dout), 32'd0);
    check("rst.valid", 32'(dout_valid), 32'd0);
    check("rst.ferr", 32'(frame_err), 32'd0);
    check("rst.ovr", 32'(overrun), 32'd0);
    clr = 1'b0;
    @(negedge clk);

    frame(8'h8D, 1'b0, 1'b1, 1'b0, "lsb");
    dout_ready = 1'b1;
    sin = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    m_valid = 1'b0;
    check("lsb.ack_valid", 32'(dout_valid), 32'd0);

    frame(8'h9D, 1'b1, 1'b1, 1'b0, "msb1");
    frame(8'hCD, 1'b1, 1'b1, 1'b1, "msb2");
    consume("msb.ack");
    gap(2, "msb.gap");

    false_start("fs");

    frame(8'hA5, 1'b0, 1'b0, 1'b0, "ferr");
    gap(2, "ferr.gap");

    frame(8'h11, 1'b0, 1'b1, 1'b0, "ovr1");
    gap(1, "ovr1.gap");
    frame(8'h22, 1'b0, 1'b1, 1'b0, "ovr2");
    check("ovr.dout11", 32'(dout), 32'h11);
    check("ovr.flag", 32'(overrun), 32'd1);
    consume("ovr.ack");
    gap(1, "ovr.gap");

    frame(8'h33, 1'b0, 1'b1, 1'b0, "pre_rst");
    sin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sin = 1'($urandom);
      repeat (CPB) @(negedge clk);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sin = 1'b1;
    model_reset();
    check("mrst.busy", 32'(busy), 32'd0);
    check("mrst.dout", 32'(dout), 32'd0);
    check("mrst.valid", 32'(dout_valid), 32'd0);
    check("mrst.ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    frame(8'h0F, 1'b0, 1'b1, 1'b0, "post_rst");
    check("post_rst.0f", 32'(dout), 32'h0F);
    consume("post_rst.ack");

    for (int i = 0; i < 40; i++) begin
      logic [BW-1:0] data;
      logic          d;
      logic          stopb;
      logic          rdy;
      data  = BW'($urandom);
      d     = 1'($urandom);
      stopb = ($urandom_range(0, 5) != 0);
      rdy   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) false_start("rnd.fs");
      frame(data, d, stopb, rdy, "rnd");
      gap($urandom_range(1, 3), "rnd.gap");
      if ($urandom_range(0, 2) == 0) consume("rnd.ack");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
